// File: rtl/sp_ram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port RAM.
// Signal names follow the arbiter's view (_i into the arbiter, _o out of it).
interface sp_ram_arbiter_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    // requester port 0 (core data side)
    logic                  m0_req_i;
    logic                  m0_gnt_o;
    logic [ADDR_WIDTH-1:0] m0_addr_i;
    logic                  m0_we_i;
    logic [BE_WIDTH-1:0]   m0_be_i;
    logic [DATA_WIDTH-1:0] m0_wdata_i;
    logic                  m0_rvalid_o;
    logic [DATA_WIDTH-1:0] m0_rdata_o;

    // requester port 1 (AXI/debug side)
    logic                  m1_req_i;
    logic                  m1_gnt_o;
    logic [ADDR_WIDTH-1:0] m1_addr_i;
    logic                  m1_we_i;
    logic [BE_WIDTH-1:0]   m1_be_i;
    logic [DATA_WIDTH-1:0] m1_wdata_i;
    logic                  m1_rvalid_o;
    logic [DATA_WIDTH-1:0] m1_rdata_o;

    // RAM side
    logic                  ram_en_o;
    logic [ADDR_WIDTH-1:0] ram_addr_o;
    logic [DATA_WIDTH-1:0] ram_wdata_o;
    logic                  ram_we_o;
    logic [BE_WIDTH-1:0]   ram_be_o;
    logic [DATA_WIDTH-1:0] ram_rdata_i;

    // the arbiter
    modport slave (
        input  m0_req_i, m0_addr_i, m0_we_i, m0_be_i, m0_wdata_i,
        input  m1_req_i, m1_addr_i, m1_we_i, m1_be_i, m1_wdata_i,
        input  ram_rdata_i,
        output m0_gnt_o, m0_rvalid_o, m0_rdata_o,
        output m1_gnt_o, m1_rvalid_o, m1_rdata_o,
        output ram_en_o, ram_addr_o, ram_wdata_o, ram_we_o, ram_be_o
    );

    // the requesters plus the RAM, seen from outside the arbiter
    modport master (
        output m0_req_i, m0_addr_i, m0_we_i, m0_be_i, m0_wdata_i,
        output m1_req_i, m1_addr_i, m1_we_i, m1_be_i, m1_wdata_i,
        output ram_rdata_i,
        input  m0_gnt_o, m0_rvalid_o, m0_rdata_o,
        input  m1_gnt_o, m1_rvalid_o, m1_rdata_o,
        input  ram_en_o, ram_addr_o, ram_wdata_o, ram_we_o, ram_be_o
    );
endinterface

// File: rtl/sp_ram_arbiter.sv
// Two-port req/gnt/rvalid arbiter in front of a single-port RAM bank.
// Grant is combinational, RAM read latency is one cycle and the response is
// steered back to whichever port owned the access. Round-robin by default,
// or port-0 priority with a starvation counter that forces port 1 through.
module sp_ram_arbiter #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32,
    parameter int FIXED_PRIO = 0,
    parameter int MAX_STALL  = 8
) (
    input  logic                 clk,
    input  logic                 rstn_i,
    sp_ram_arbiter_if.slave      bus
);
    localparam int         BE_WIDTH  = DATA_WIDTH / 8;
    localparam logic [7:0] STALL_MAX = 8'(MAX_STALL);

    logic [1:0]            gnt;
    logic                  pick1;
    logic                  last_gnt;      // 1 = port 1 received the most recent grant
    logic [7:0]            stall_cnt;     // consecutive cycles port 1 was refused
    logic [1:0]            rvalid_owner;  // which port the RAM data belongs to this cycle
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_we;
    logic [BE_WIDTH-1:0]   sel_be;

    // Grant: a lone requester wins outright; conflicts go to the policy.
    // Grants are held off entirely while reset is asserted.
    always_comb begin
        if (FIXED_PRIO != 0) pick1 = (stall_cnt == STALL_MAX);
        else                 pick1 = ~last_gnt;
        gnt = 2'b00;
        if (rstn_i) begin
            if (bus.m0_req_i && bus.m1_req_i) gnt = pick1 ? 2'b10 : 2'b01;
            else                              gnt = {bus.m1_req_i, bus.m0_req_i};
        end
    end

    // Arbitration history and response ownership
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            last_gnt     <= 1'b1;
            stall_cnt    <= 8'd0;
            rvalid_owner <= 2'b00;
        end else begin
            rvalid_owner <= gnt;
            if (|gnt) last_gnt <= gnt[1];
            if (FIXED_PRIO == 0 || !bus.m1_req_i || gnt[1]) stall_cnt <= 8'd0;
            else if (stall_cnt != STALL_MAX)                 stall_cnt <= stall_cnt + 8'd1;
        end
    end

    // RAM-side mux: addr/wdata default to port 0 when idle, control is gated
    always_comb begin
        sel_addr  = gnt[1] ? bus.m1_addr_i  : bus.m0_addr_i;
        sel_wdata = gnt[1] ? bus.m1_wdata_i : bus.m0_wdata_i;
        sel_we    = 1'b0;
        sel_be    = '0;
        if (gnt[1]) begin
            sel_we = bus.m1_we_i;
            sel_be = bus.m1_be_i;
        end else if (gnt[0]) begin
            sel_we = bus.m0_we_i;
            sel_be = bus.m0_be_i;
        end
    end

    assign bus.m0_gnt_o    = gnt[0];
    assign bus.m1_gnt_o    = gnt[1];
    assign bus.ram_en_o    = |gnt;
    assign bus.ram_addr_o  = sel_addr;
    assign bus.ram_wdata_o = sel_wdata;
    assign bus.ram_we_o    = sel_we;
    assign bus.ram_be_o    = sel_be;

    assign bus.m0_rvalid_o = rvalid_owner[0];
    assign bus.m1_rvalid_o = rvalid_owner[1];
    assign bus.m0_rdata_o  = rvalid_owner[0] ? bus.ram_rdata_i : '0;
    assign bus.m1_rdata_o  = rvalid_owner[1] ? bus.ram_rdata_i : '0;
endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Bench: one round-robin and one fixed-priority (MAX_STALL=3) arbiter, each
// with its own RAM stand-in, checked cycle by cycle against a transaction-level
// model (winner choice, response owner, expected word memory).
module tb_sp_ram_arbiter;
    localparam int MS = 3;

    typedef struct {
        logic        req;
        logic        we;
        logic [14:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } port_t;

    logic clk;
    logic rst_n;

    sp_ram_arbiter_if #(.ADDR_WIDTH(15), .DATA_WIDTH(32)) bus0 ();
    sp_ram_arbiter_if #(.ADDR_WIDTH(15), .DATA_WIDTH(32)) bus1 ();

    sp_ram_arbiter #(.ADDR_WIDTH(15), .DATA_WIDTH(32), .FIXED_PRIO(0), .MAX_STALL(8))
        dut_rr (.clk(clk), .rstn_i(rst_n), .bus(bus0));
    sp_ram_arbiter #(.ADDR_WIDTH(15), .DATA_WIDTH(32), .FIXED_PRIO(1), .MAX_STALL(MS))
        dut_fp (.clk(clk), .rstn_i(rst_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // stimulus and model state, index [dut][port]
    port_t       p   [2][2];
    int          ew  [2];      // winner of the current cycle, -1 = none
    int          m_last [2];   // port that got the latest grant
    int          m_stall [2];  // consecutive refusals of port 1
    logic [1:0]  m_own [2];    // response owner for the current cycle
    logic [31:0] m_rd [2];     // data the owner must see
    logic [31:0] emem [2][16]; // expected memory contents
    logic [31:0] ram  [2][16]; // RAM stand-ins driven by the DUTs
    int          n_chk, n_err;

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    // RAM stand-ins: synchronous read of the old word, byte-masked write
    always @(posedge clk) begin
        if (bus0.ram_en_o) begin
            bus0.ram_rdata_i <= ram[0][bus0.ram_addr_o[5:2]];
            if (bus0.ram_we_o)
                ram[0][bus0.ram_addr_o[5:2]] <= merge(ram[0][bus0.ram_addr_o[5:2]], bus0.ram_wdata_o, bus0.ram_be_o);
        end
    end
    always @(posedge clk) begin
        if (bus1.ram_en_o) begin
            bus1.ram_rdata_i <= ram[1][bus1.ram_addr_o[5:2]];
            if (bus1.ram_we_o)
                ram[1][bus1.ram_addr_o[5:2]] <= merge(ram[1][bus1.ram_addr_o[5:2]], bus1.ram_wdata_o, bus1.ram_be_o);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // winner under the arbitration rules, from requests and history
    function automatic int winner(int d);
        logic r0, r1;
        r0 = p[d][0].req;
        r1 = p[d][1].req;
        if (!rst_n) return -1;
        if (r0 && r1) begin
            if (d == 0) return (m_last[d] == 1) ? 0 : 1;
            return (m_stall[d] == MS) ? 1 : 0;
        end
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    task automatic check_dut(input int d, input logic g0, input logic g1, input logic en,
                             input logic we, input logic [3:0] be, input logic [14:0] addr,
                             input logic [31:0] wd, input logic v0, input logic v1,
                             input logic [31:0] r0, input logic [31:0] r1);
        int w, s;
        logic own0, own1;
        w = winner(d);
        ew[d] = w;
        s = (w == 1) ? 1 : 0;
        own0 = rst_n && m_own[d][0];
        own1 = rst_n && m_own[d][1];
        chk($sformatf("d%0d gnt0", d), 64'(g0), 64'(w == 0));
        chk($sformatf("d%0d gnt1", d), 64'(g1), 64'(w == 1));
        chk($sformatf("d%0d ram_en", d), 64'(en), 64'(w >= 0));
        chk($sformatf("d%0d ram_we", d), 64'(we), 64'((w >= 0) ? p[d][s].we : 1'b0));
        chk($sformatf("d%0d ram_be", d), 64'(be), 64'((w >= 0) ? p[d][s].be : 4'h0));
        chk($sformatf("d%0d ram_addr", d), 64'(addr), 64'(p[d][s].addr));
        chk($sformatf("d%0d ram_wdata", d), 64'(wd), 64'(p[d][s].wdata));
        chk($sformatf("d%0d rvalid0", d), 64'(v0), 64'(own0));
        chk($sformatf("d%0d rvalid1", d), 64'(v1), 64'(own1));
        chk($sformatf("d%0d rdata0", d), 64'(r0), 64'(own0 ? m_rd[d] : 32'h0));
        chk($sformatf("d%0d rdata1", d), 64'(r1), 64'(own1 ? m_rd[d] : 32'h0));
    endtask

    task automatic apply();
        bus0.m0_req_i = p[0][0].req; bus0.m0_we_i = p[0][0].we; bus0.m0_addr_i = p[0][0].addr;
        bus0.m0_be_i  = p[0][0].be;  bus0.m0_wdata_i = p[0][0].wdata;
        bus0.m1_req_i = p[0][1].req; bus0.m1_we_i = p[0][1].we; bus0.m1_addr_i = p[0][1].addr;
        bus0.m1_be_i  = p[0][1].be;  bus0.m1_wdata_i = p[0][1].wdata;
        bus1.m0_req_i = p[1][0].req; bus1.m0_we_i = p[1][0].we; bus1.m0_addr_i = p[1][0].addr;
        bus1.m0_be_i  = p[1][0].be;  bus1.m0_wdata_i = p[1][0].wdata;
        bus1.m1_req_i = p[1][1].req; bus1.m1_we_i = p[1][1].we; bus1.m1_addr_i = p[1][1].addr;
        bus1.m1_be_i  = p[1][1].be;  bus1.m1_wdata_i = p[1][1].wdata;
    endtask

    // drive inputs, let them settle well before the next edge, then check
    task automatic settle();
        apply();
        #3;
        check_dut(0, bus0.m0_gnt_o, bus0.m1_gnt_o, bus0.ram_en_o, bus0.ram_we_o, bus0.ram_be_o,
                  bus0.ram_addr_o, bus0.ram_wdata_o, bus0.m0_rvalid_o, bus0.m1_rvalid_o,
                  bus0.m0_rdata_o, bus0.m1_rdata_o);
        check_dut(1, bus1.m0_gnt_o, bus1.m1_gnt_o, bus1.ram_en_o, bus1.ram_we_o, bus1.ram_be_o,
                  bus1.ram_addr_o, bus1.ram_wdata_o, bus1.m0_rvalid_o, bus1.m1_rvalid_o,
                  bus1.m0_rdata_o, bus1.m1_rdata_o);
    endtask

    // commit the cycle's transaction to the model, then move past the edge
    task automatic advance();
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_own[d] = 2'b00; m_last[d] = 1; m_stall[d] = 0;
            end else begin
                int w;
                w = ew[d];
                m_own[d] = {w == 1, w == 0};
                if (p[d][1].req && w != 1) m_stall[d] = (m_stall[d] < MS) ? m_stall[d] + 1 : MS;
                else                       m_stall[d] = 0;
                if (w >= 0) begin
                    m_last[d] = w;
                    m_rd[d] = emem[d][p[d][w].addr[5:2]];
                    if (p[d][w].we)
                        emem[d][p[d][w].addr[5:2]] = merge(emem[d][p[d][w].addr[5:2]], p[d][w].wdata, p[d][w].be);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic setp(input int d, input int n, input logic req, input logic we,
                        input logic [14:0] addr, input logic [3:0] be, input logic [31:0] wd);
        p[d][n].req = req; p[d][n].we = we; p[d][n].addr = addr; p[d][n].be = be; p[d][n].wdata = wd;
    endtask

    task automatic idle_all();
        for (int d = 0; d < 2; d++) for (int n = 0; n < 2; n++) p[d][n].req = 1'b0;
    endtask

    // requesters hold a pending request until granted, occasionally withdraw it
    task automatic rand_stim();
        for (int d = 0; d < 2; d++)
            for (int n = 0; n < 2; n++) begin
                if (!p[d][n].req || ew[d] == n)
                    setp(d, n, $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
                         15'($urandom_range(0, 15) << 2), 4'($urandom), $urandom);
                else if ($urandom_range(0, 15) == 0)
                    p[d][n].req = 1'b0;
            end
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        idle_all();
        for (int i = 0; i < cycles; i++) begin settle(); advance(); end
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] pat;
        n_chk = 0; n_err = 0;
        for (int d = 0; d < 2; d++) begin
            ew[d] = -1; m_last[d] = 1; m_stall[d] = 0; m_own[d] = 2'b00; m_rd[d] = 32'h0;
            for (int i = 0; i < 16; i++) begin emem[d][i] = 32'h0; ram[d][i] = 32'h0; end
            for (int n = 0; n < 2; n++) setp(d, n, 1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
        end
        bus0.ram_rdata_i = 32'h0;
        bus1.ram_rdata_i = 32'h0;
        #1;
        do_reset(3);

        // preload 0x10, then single port-0 read of it
        setp(0, 0, 1'b1, 1'b1, 15'h10, 4'hF, 32'hDEADBEEF);
        settle(); advance();
        setp(0, 0, 1'b1, 1'b0, 15'h10, 4'h0, 32'h0);
        settle();
        chk("single rd gnt", 64'(bus0.m0_gnt_o), 64'h1);
        advance();
        idle_all();
        settle();
        chk("single rd data", 64'(bus0.m0_rdata_o), 64'hDEADBEEF);
        chk("single rd no rv1", 64'(bus0.m1_rvalid_o), 64'h0);
        advance();

        // byte-enable write by port 1, then read back
        setp(0, 1, 1'b1, 1'b1, 15'h20, 4'hF, 32'hFFFFFFFF);
        settle(); advance();
        setp(0, 1, 1'b1, 1'b1, 15'h20, 4'b0101, 32'h11223344);
        settle(); advance();
        setp(0, 1, 1'b1, 1'b0, 15'h20, 4'h0, 32'h0);
        settle();
        chk("be wr rvalid1", 64'(bus0.m1_rvalid_o), 64'h1);
        advance();
        idle_all();
        settle();
        chk("be rd data", 64'(bus0.m1_rdata_o), 64'hFF22FF44);
        advance();

        // response on port 0 overlaps the grant for port 1
        setp(0, 0, 1'b1, 1'b0, 15'h10, 4'h0, 32'h0);
        settle(); advance();
        idle_all();
        setp(0, 1, 1'b1, 1'b0, 15'h20, 4'h0, 32'h0);
        settle();
        chk("overlap rv0", 64'(bus0.m0_rvalid_o), 64'h1);
        chk("overlap gnt1", 64'(bus0.m1_gnt_o), 64'h1);
        advance();
        idle_all();
        settle();
        chk("overlap rdata1", 64'(bus0.m1_rdata_o), 64'hFF22FF44);
        advance();

        // continuous conflict right after reset on both policies
        do_reset(1);
        pat = 8'h0;
        for (int i = 0; i < 8; i++) begin
            for (int d = 0; d < 2; d++)
                for (int n = 0; n < 2; n++)
                    if (!p[d][n].req || ew[d] == n)
                        setp(d, n, 1'b1, 1'b0, 15'((4 * i + 2 * n + d) & 15) << 2, 4'h0, 32'h0);
            settle();
            pat[i] = bus1.m1_gnt_o;
            chk($sformatf("rr order %0d", i), 64'(bus0.m1_gnt_o), 64'(i % 2));
            advance();
        end
        chk("fixed prio order", 64'(pat), 64'h88);

        // reset right after a grant discards the response
        idle_all();
        settle(); advance();
        setp(0, 0, 1'b1, 1'b0, 15'h10, 4'h0, 32'h0);
        settle(); advance();
        rst_n = 1'b0;
        setp(0, 1, 1'b1, 1'b0, 15'h20, 4'h0, 32'h0);
        settle();
        chk("rst rv0", 64'(bus0.m0_rvalid_o), 64'h0);
        chk("rst gnt", 64'({bus0.m0_gnt_o, bus0.m1_gnt_o}), 64'h0);
        advance();
        rst_n = 1'b1;
        settle();
        chk("post rst winner", 64'(bus0.m0_gnt_o), 64'h1);
        advance();

        // randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            if (c % 700 == 699) rst_n = 1'b0;
            else rst_n = 1'b1;
            rand_stim();
            settle();
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/sp_ram_arbiter.md
Name: sp_ram_arbiter

Overview:
- Two-port arbiter placed in front of sp_ram_wrap.
- Lets two requesters (port 0: core data side, port 1: AXI/debug side) share one single-port RAM bank.
- Uses the codebase req/gnt/rvalid protocol: combinational grant, 1-cycle RAM read latency, response routed back to the granted port.
- Supports round-robin mode, or fixed priority to port 0 with a starvation limit for port 1.

Parameters:
ADDR_WIDTH, 15, byte address width presented to the RAM
DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8
FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 priority with starvation guard
MAX_STALL, 8, FIXED_PRIO=1 only: consecutive denied cycles after which port 1 is forced to win (1..255)

Ports:
clk  input  1  clock
rstn_i  input  1  asynchronous reset, active-low
m0_req_i / m1_req_i  input  1  access request
m0_gnt_o / m1_gnt_o  output  1  request accepted this cycle (combinational)
m0_addr_i / m1_addr_i  input  ADDR_WIDTH  byte address
m0_we_i / m1_we_i  input  1  1 = write, 0 = read
m0_be_i / m1_be_i  input  DATA_WIDTH/8  byte enables
m0_wdata_i / m1_wdata_i  input  DATA_WIDTH  write data
m0_rvalid_o / m1_rvalid_o  output  1  response valid, one cycle after grant
m0_rdata_o / m1_rdata_o  output  DATA_WIDTH  read data
ram_en_o  output  1  RAM enable, to sp_ram_wrap en_i
ram_addr_o  output  ADDR_WIDTH  RAM address
ram_wdata_o  output  DATA_WIDTH  RAM write data
ram_we_o  output  1  RAM write enable
ram_be_o  output  DATA_WIDTH/8  RAM byte enables
ram_rdata_i  input  DATA_WIDTH  RAM read data, valid the cycle after ram_en_o

Behaviour:
- At most one grant per cycle. gnt is combinational from req and arbiter state. The RAM side mirrors the granted port's addr/we/be/wdata in the same cycle, with ram_en_o = m0_gnt_o | m1_gnt_o.
- When nothing is granted: ram_en_o=0, ram_we_o=0, ram_be_o=0. ram_addr_o and ram_wdata_o are don't-care but driven from port 0.
- Single requester: that port is granted immediately.
- Both requesting, FIXED_PRIO=0: grant the port that did not win the last contested-or-uncontested grant.
  - last_gnt register: reset 1, so port 0 wins the first conflict.
  - last_gnt updates on every grant.
- Both requesting, FIXED_PRIO=1: port 0 wins, unless stall_cnt == MAX_STALL, in which case port 1 wins.
- stall_cnt (FIXED_PRIO=1 only):
  - Increments, saturating at MAX_STALL, each cycle m1_req_i=1 and m1_gnt_o=0.
  - Clears to 0 when port 1 is granted or m1_req_i=0.
  - Reset value 0.
- Response tracking:
  - Registered rvalid_owner[1:0]: bit n set the cycle after port n was granted, for reads and writes alike.
  - mN_rvalid_o = rvalid_owner[n].
  - mN_rdata_o = ram_rdata_i when rvalid_owner[n], else 0.
- Back-to-back: a new grant may be issued in the same cycle the previous response is returned. Sustained throughput is 1 access/cycle.
- A requester holds req, addr, we, be and wdata stable until gnt. Dropping req before gnt is permitted; the request is then simply not served.
- Reset values:
  - all gnt and rvalid = 0 (gnt gated while rstn_i low)
  - rdata = 0, ram_en_o = 0, ram_we_o = 0
  - last_gnt = 1, stall_cnt = 0
- Reset mid-access: any in-flight rvalid is discarded and not replayed.
- The RAM write in the reset cycle is blocked because gnt is forced low during reset.

Test Plan:
- Single read, port 0 only, addr 0x10 (pre-written 0xDEADBEEF): m0_gnt_o=1 in cycle 0; m0_rvalid_o=1 with m0_rdata_o=0xDEADBEEF in cycle 1; m1_rvalid_o stays 0.
- Round-robin (FIXED_PRIO=0), both ports hold req for 4 cycles with distinct addresses: grants alternate 0,1,0,1; rvalid follows each grant by one cycle on the matching port only.
- Byte-enable write by port 1: addr 0x20, wdata 0x11223344, be 4'b0101 over 0xFFFFFFFF, then read back → 0xFF22FF44; port 1 also receives rvalid for the write.
- Fixed priority (FIXED_PRIO=1, MAX_STALL=3), both request continuously: grants go 0,0,0,1,0,0,0,1; stall_cnt clears after each port-1 grant.
- Simultaneous response and new request: port 0 read granted cycle 0, port 1 read granted cycle 1; cycle 1 has m0_rvalid_o=1 and m1_gnt_o=1; cycle 2 has m1_rvalid_o=1, and m1_rdata_o shows port 1's data, not port 0's.
- Reset asserted the cycle after a grant: both rvalid = 0 immediately, no gnt while rstn_i=0; after release, the first conflict is won by port 0.
